// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses instruction memory and
// registers the returned word into IF/ID, honouring stall, redirect and range faults.
module fetch_unit #(
    parameter int          instrn   = 7,
    parameter int          ilen     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [instrn-1:0] imem_addr,
    input  logic [ilen-1:0]   imem_instr,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc4,
    output logic [ilen-1:0]   if_instr,
    output logic              if_valid,
    output logic              misalign_err,
    output logic              range_err
);

    localparam logic [ilen-1:0] NOP = ilen'(32'h0000_0013);

    typedef enum logic [2:0] {
        ACT_HALT,
        ACT_REDIRECT,
        ACT_MISALIGN,
        ACT_STALL,
        ACT_FETCH,
        ACT_RANGE
    } action_t;

    logic [31:0] pc;
    logic        in_range;
    action_t     action;

    assign imem_addr = pc[instrn+1:2];
    assign in_range  = (pc >> (instrn + 2)) == 32'd0;
    assign if_pc4    = if_pc + 32'd4;

    // Priority decode of what this edge does; a redirect overrides stall.
    always_comb begin
        // NOTE: default first so every path assigns action and no latch is inferred.
        action = ACT_FETCH;
        if (range_err)
            action = ACT_HALT;
        else if (redirect && redirect_pc[1:0] == 2'b00)
            action = ACT_REDIRECT;
        else if (redirect)
            action = ACT_MISALIGN;
        else if (stall)
            action = ACT_STALL;
        else if (!in_range)
            action = ACT_RANGE;
    end

    // Squashed slots carry a NOP tagged with the current pc so IF/ID stays well defined.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            if_pc        <= RESET_PC;
            if_instr     <= NOP;
            if_valid     <= 1'b0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            misalign_err <= 1'b0;
            unique case (action)
                ACT_FETCH: begin
                    if_instr <= imem_instr;
                    if_pc    <= pc;
                    if_valid <= 1'b1;
                    pc       <= pc + 32'd4;
                end
                ACT_REDIRECT: begin
                    pc       <= redirect_pc;
                    if_pc    <= pc;
                    if_instr <= NOP;
                    if_valid <= 1'b0;
                end
                ACT_MISALIGN: begin
                    misalign_err <= 1'b1;
                    if_pc        <= pc;
                    if_instr     <= NOP;
                    if_valid     <= 1'b0;
                end
                ACT_RANGE: begin
                    range_err <= 1'b1;
                    if_pc     <= pc;
                    if_instr  <= NOP;
                    if_valid  <= 1'b0;
                end
                ACT_HALT: begin
                    if_pc    <= pc;
                    if_instr <= NOP;
                    if_valid <= 1'b0;
                end
                ACT_STALL: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RISC-V core and the reading side of the instruction memory interface. Holds the program counter, drives the word address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. Accepts stall from hazard logic and taken branch/jump redirects from execute. Flags misaligned redirect targets and fetches beyond the implemented memory.

## Interface
Parameters:
- instrn, 7, instruction memory word-address width (memory holds 2^instrn words)
- ilen, 32, instruction width in bits
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous and active-high
- stall  input  1  hold PC and IF/ID register
- redirect  input  1  taken branch/jump from execute this cycle
- redirect_pc  input  32  byte target of the redirect
- imem_addr  output  instrn  word address to instruction memory, pc[instrn+1:2]
- imem_instr  input  ilen  combinational read data from instruction memory
- if_pc  output  32  byte PC of the instruction in IF/ID
- if_pc4  output  32  if_pc + 4
- if_instr  output  ilen  instruction in IF/ID
- if_valid  output  1  IF/ID holds a real instruction
- misalign_err  output  1  one-cycle pulse: redirect target not word aligned
- range_err  output  1  sticky: PC left the implemented memory; fetch halted

## Operation
- State: pc (32), IF/ID register {if_pc, if_instr, if_valid}, misalign_err, range_err.
- imem_addr is combinational from pc; imem_instr returns in the same cycle.
- in_range = (pc >> (instrn+2)) == 0.
- Per-edge priority, highest first:
  1. range_err set: pc holds, if_valid <= 0; other inputs ignored until reset.
  2. redirect with redirect_pc[1:0] == 0: pc <= redirect_pc; if_valid <= 0 (flush of the wrong-path fetch); applies even when stall is high.
  3. redirect with redirect_pc[1:0] != 0: pc holds; if_valid <= 0; misalign_err <= 1 for one cycle.
  4. stall: pc, if_pc, if_instr, if_valid all hold.
  5. Normal, in_range: if_instr <= imem_instr, if_pc <= pc, if_valid <= 1, pc <= pc + 4.
  6. Normal, !in_range: range_err <= 1, if_valid <= 0, pc holds.
- misalign_err clears on the following edge unless retriggered.
- pc + 4 wraps modulo 2^32; after wrap, the range check applies to the new pc.
- Squashed slots load if_instr with NOP 32'h0000_0013 and if_pc with pc.
- if_pc4 is combinational: if_pc + 4, modulo 2^32.

## Timing
- Reset (asynchronous, any time, including mid-stall or mid-redirect): pc = RESET_PC, if_pc = RESET_PC, if_instr = 32'h0000_0013, if_valid = 0, misalign_err = 0, range_err = 0. The first valid instruction appears in IF/ID one edge after rst deasserts.
- Latency: the instruction at pc is in IF/ID one edge after pc is presented. Throughput is one instruction per cycle without stall or redirect.
- Redirect penalty: one bubble (if_valid = 0) in IF/ID; the target instruction appears in IF/ID on the second edge after the redirect.
- Stall for N cycles holds the outputs for N edges; fetch resumes with the held pc, with no skipped or duplicated instruction.
- Redirect and stall in the same cycle: the redirect wins; the stall is ignored for that edge.

## Test plan
- Reset then free-run, RESET_PC = 0, memory words 0..3 = 0x11,0x22,0x33,0x44 -> if_pc 0,4,8,12 on successive edges; if_instr matches; if_valid = 1 from the first edge.
- Stall held 3 cycles while if_pc = 8 -> if_pc/if_instr/if_valid remain 8/0x33/1 for 3 edges; the next edge gives if_pc = 12.
- Redirect to 0x40 while if_pc = 4, with stall also high -> next edge: if_valid = 0; the edge after: if_pc = 0x40, if_instr = mem[16], valid = 1.
- Redirect to 0x42 -> misalign_err high for exactly one cycle; if_valid = 0 for one edge; the sequential stream then resumes at the held pc.
- With instrn = 7, run sequentially to pc = 0x200 -> range_err = 1 and stays set; if_valid = 0; later redirects ignored; rst clears everything.
- Assert rst mid-stream with redirect high -> outputs reach reset values immediately, without waiting for a clock edge; fetch restarts at RESET_PC.
